// File: rtl/playback_ctrl.sv
// ---------------------------------------------------------------------------
// playback_ctrl
//   Top-level sequencer for the song playback datapath. Converts debounced
//   front-panel pulses (play/pause, next, prev) and rewind/ff levels into the
//   control signals of the song reader, and issues a restart window
//   (player_reset) on every song change so the reader re-initialises.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset
//   play_button    in   one-cycle pulse, toggle play/pause
//   next_button    in   one-cycle pulse, select next song
//   prev_button    in   one-cycle pulse, select previous song
//   rewind_button  in   level, request rewind
//   ff_button      in   level, request fast-forward
//   song_done      in   one-cycle pulse from the reader at end of song
//   play           out  run enable to the song reader
//   song           out  current song index (SONG_W bits)
//   player_reset   out  synchronous restart to reader and note player
//   rewind         out  rewind enable to the song reader
//   ff             out  fast-forward enable to the song reader
//   busy           out  high while a song switch is in progress
// ---------------------------------------------------------------------------
module playback_ctrl #(
    parameter int NUM_SONGS     = 4,
    parameter int SONG_W        = 2,
    parameter int SWITCH_CYCLES = 2,
    parameter int LOOP          = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              rewind_button,
    input  logic              ff_button,
    input  logic              song_done,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              player_reset,
    output logic              rewind,
    output logic              ff,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_SWITCH  = 2'd2
    } state_t;

    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
    localparam logic [SONG_W-1:0] SONG_ONE  = SONG_W'(1);
    localparam logic [3:0]        CNT_LOAD  = 4'(SWITCH_CYCLES - 1);

    state_t            state_r;
    state_t            state_s;
    logic [SONG_W-1:0] song_r;
    logic [SONG_W-1:0] song_s;
    logic              resume_r;
    logic              resume_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              rewind_r;
    logic              ff_r;
    logic              play_s;
    logic              switch_s;

    // Next song index, wrapping from the last song back to song 0.
    function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s);
        logic [SONG_W-1:0] r;
        if (s == LAST_SONG) begin
            r = '0;
        end else begin
            r = s + SONG_ONE;
        end
        return r;
    endfunction

    // Previous song index, wrapping from song 0 to the last song.
    function automatic logic [SONG_W-1:0] song_dec(input logic [SONG_W-1:0] s);
        logic [SONG_W-1:0] r;
        if (s == '0) begin
            r = LAST_SONG;
        end else begin
            r = s - SONG_ONE;
        end
        return r;
    endfunction

    // State, song, resume flag and restart-window counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_PAUSED;
            song_r   <= '0;
            resume_r <= 1'b0;
            cnt_r    <= 4'd0;
        end else begin
            state_r  <= state_s;
            song_r   <= song_s;
            resume_r <= resume_s;
            cnt_r    <= cnt_s;
        end
    end

    // Next-state logic; events are prioritised next > prev > song_done > play.
    always_comb begin
        state_s  = state_r;
        song_s   = song_r;
        resume_s = resume_r;
        cnt_s    = cnt_r;
        case (state_r)
            ST_PAUSED: begin
                if (next_button) begin
                    state_s  = ST_SWITCH;
                    song_s   = song_inc(song_r);
                    resume_s = 1'b0;
                    cnt_s    = CNT_LOAD;
                end else if (prev_button) begin
                    state_s  = ST_SWITCH;
                    song_s   = song_dec(song_r);
                    resume_s = 1'b0;
                    cnt_s    = CNT_LOAD;
                end else if (play_button) begin
                    state_s = ST_PLAYING;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_PLAYING: begin
                if (next_button) begin
                    state_s  = ST_SWITCH;
                    song_s   = song_inc(song_r);
                    resume_s = 1'b1;
                    cnt_s    = CNT_LOAD;
                end else if (prev_button) begin
                    state_s  = ST_SWITCH;
                    song_s   = song_dec(song_r);
                    resume_s = 1'b1;
                    cnt_s    = CNT_LOAD;
                end else if (song_done) begin
                    state_s = ST_SWITCH;
                    cnt_s   = CNT_LOAD;
                    if ((song_r != LAST_SONG) || (LOOP != 0)) begin
                        song_s   = song_inc(song_r);
                        resume_s = 1'b1;
                    end else begin
                        // End of the list without looping: restart the last
                        // song from its beginning and come back paused.
                        resume_s = 1'b0;
                    end
                end else if (play_button) begin
                    state_s = ST_PAUSED;
                end else begin
                    state_s = ST_PLAYING;
                end
            end
            ST_SWITCH: begin
                if (next_button) begin
                    song_s = song_inc(song_r);
                    cnt_s  = CNT_LOAD;
                end else if (prev_button) begin
                    song_s = song_dec(song_r);
                    cnt_s  = CNT_LOAD;
                end else if (play_button) begin
                    // A play toggle only changes where we land; the window
                    // keeps counting down but cannot close on this cycle.
                    resume_s = ~resume_r;
                    if (cnt_r != 4'd0) begin
                        cnt_s = cnt_r - 4'd1;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else if (cnt_r == 4'd0) begin
                    state_s = resume_r ? ST_PLAYING : ST_PAUSED;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s  = ST_PAUSED;
                song_s   = '0;
                resume_s = 1'b0;
                cnt_s    = 4'd0;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        play_s   = 1'b0;
        switch_s = 1'b0;
        case (state_r)
            ST_PLAYING: begin
                play_s   = 1'b1;
                switch_s = 1'b0;
            end
            ST_SWITCH: begin
                play_s   = 1'b0;
                switch_s = 1'b1;
            end
            default: begin
                play_s   = 1'b0;
                switch_s = 1'b0;
            end
        endcase
    end

    // Rewind/ff enables, qualified by PLAYING; rewind wins when both held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rewind_r <= 1'b0;
            ff_r     <= 1'b0;
        end else begin
            rewind_r <= rewind_button & (state_r == ST_PLAYING);
            ff_r     <= ff_button & ~rewind_button & (state_r == ST_PLAYING);
        end
    end

    assign play         = play_s;
    assign player_reset = switch_s;
    assign busy         = switch_s;
    assign song         = song_r;
    assign rewind       = rewind_r;
    assign ff           = ff_r;

endmodule

// File: tb/tb_playback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_playback_ctrl
//   Drives two playback_ctrl instances (LOOP=1 and LOOP=0) with the same
//   stimulus: a directed sequence followed by random pulses and levels.
//   A behavioural model tracks mode, song, resume intent and the number of
//   restart cycles still owed, and every cycle the outputs are compared.
// ---------------------------------------------------------------------------
module tb_playback_ctrl;

    localparam int N_SONGS = 4;
    localparam int SW_CYC  = 2;

    logic clk = 1'b0;
    logic reset;
    logic play_button, next_button, prev_button;
    logic rewind_button, ff_button, song_done;

    logic [1:0] play_w, prst_w, rew_w, ff_w, busy_w;
    logic [1:0] song_w [2];

    int compared   = 0;
    int mismatched = 0;

    // model: mode 0=paused 1=playing 2=switching
    int m_mode [2];
    int m_song [2];
    bit m_resume [2];
    int m_left [2];
    bit m_rew [2];
    bit m_ff [2];
    bit m_loop [2];

    always #5 clk = ~clk;

    playback_ctrl #(.NUM_SONGS(N_SONGS), .SONG_W(2), .SWITCH_CYCLES(SW_CYC), .LOOP(1)) dut_loop (
        .clk(clk), .reset(reset),
        .play_button(play_button), .next_button(next_button), .prev_button(prev_button),
        .rewind_button(rewind_button), .ff_button(ff_button), .song_done(song_done),
        .play(play_w[0]), .song(song_w[0]), .player_reset(prst_w[0]),
        .rewind(rew_w[0]), .ff(ff_w[0]), .busy(busy_w[0])
    );

    playback_ctrl #(.NUM_SONGS(N_SONGS), .SONG_W(2), .SWITCH_CYCLES(SW_CYC), .LOOP(0)) dut_stop (
        .clk(clk), .reset(reset),
        .play_button(play_button), .next_button(next_button), .prev_button(prev_button),
        .rewind_button(rewind_button), .ff_button(ff_button), .song_done(song_done),
        .play(play_w[1]), .song(song_w[1]), .player_reset(prst_w[1]),
        .rewind(rew_w[1]), .ff(ff_w[1]), .busy(busy_w[1])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]   = 0;
            m_song[k]   = 0;
            m_resume[k] = 1'b0;
            m_left[k]   = 0;
            m_rew[k]    = 1'b0;
            m_ff[k]     = 1'b0;
        end
    endtask

    task automatic model_enter(input int k, input int new_song, input bit res);
        m_song[k]   = new_song;
        m_resume[k] = res;
        m_mode[k]   = 2;
        m_left[k]   = SW_CYC;
    endtask

    task automatic model_step(input bit pb, input bit nb, input bit vb,
                              input bit rb, input bit fb, input bit db);
        for (int k = 0; k < 2; k++) begin
            int up;
            int dn;
            up = (m_song[k] + 1) % N_SONGS;
            dn = (m_song[k] + N_SONGS - 1) % N_SONGS;
            m_rew[k] = rb && (m_mode[k] == 1);
            m_ff[k]  = fb && !rb && (m_mode[k] == 1);
            if (m_mode[k] == 0) begin
                if (nb)      model_enter(k, up, 1'b0);
                else if (vb) model_enter(k, dn, 1'b0);
                else if (pb) m_mode[k] = 1;
            end else if (m_mode[k] == 1) begin
                if (nb)      model_enter(k, up, 1'b1);
                else if (vb) model_enter(k, dn, 1'b1);
                else if (db) begin
                    if (m_song[k] != N_SONGS - 1 || m_loop[k]) model_enter(k, up, 1'b1);
                    else                                       model_enter(k, m_song[k], 1'b0);
                end else if (pb) m_mode[k] = 0;
            end else begin
                // m_left = restart cycles still owed, counting the current one
                if (nb || vb) begin
                    m_song[k] = nb ? up : dn;
                    m_left[k] = SW_CYC;
                end else if (pb) begin
                    m_resume[k] = !m_resume[k];
                    m_left[k]   = (m_left[k] - 1 < 1) ? 1 : m_left[k] - 1;
                end else begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) m_mode[k] = m_resume[k] ? 1 : 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] obs;
            logic [7:0] exp;
            obs = {1'b0, play_w[k], song_w[k], prst_w[k], rew_w[k], ff_w[k], busy_w[k]};
            exp = {1'b0, 1'(m_mode[k] == 1), 2'(m_song[k]), 1'(m_mode[k] == 2),
                   m_rew[k], m_ff[k], 1'(m_mode[k] == 2)};
            check($sformatf("dut%0d_outputs", k), obs, exp);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, compare at negedge.
    task automatic step(input bit pb, input bit nb, input bit vb,
                        input bit rb, input bit fb, input bit db);
        play_button   = pb;
        next_button   = nb;
        prev_button   = vb;
        rewind_button = rb;
        ff_button     = fb;
        song_done     = db;
        @(posedge clk);
        model_step(pb, nb, vb, rb, fb, db);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit rb_lvl;
        bit fb_lvl;
        m_loop[0] = 1'b1;
        m_loop[1] = 1'b0;
        reset = 1'b0;
        play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0;
        rewind_button = 1'b0; ff_button = 1'b0; song_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // idle after reset
        repeat (10) idle();

        // play toggles, then next+play in the same cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("play_on", {7'd0, play_w[0]}, 8'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("play_off", {7'd0, play_w[0]}, 8'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("next_beats_play_song", {6'd0, song_w[0]}, 8'd1);
        check("next_beats_play_state", {6'd0, play_w[0], busy_w[0]}, 8'd1);
        idle(); idle();

        // reach PLAYING on song 2, then next -> song 3 with 2-cycle restart
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(); idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("next_song3", {6'd0, song_w[0]}, 8'd3);
        check("prst_cycle1", {7'd0, prst_w[0]}, 8'd1);
        idle();
        check("prst_cycle2", {7'd0, prst_w[0]}, 8'd1);
        idle();
        check("resume_play", {6'd0, play_w[0], prst_w[0]}, 8'd2);

        // song_done on the last song: wrap (LOOP=1) versus restart-and-stop (LOOP=0)
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("done_loop_song", {6'd0, song_w[0]}, 8'd0);
        check("done_stop_song", {6'd0, song_w[1]}, 8'd3);
        idle(); idle();
        check("done_loop_play", {7'd0, play_w[0]}, 8'd1);
        check("done_stop_play", {7'd0, play_w[1]}, 8'd0);

        // prev from song 0 wraps, next inside the window extends it to 3 cycles
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("prev_wrap", {6'd0, song_w[0]}, 8'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("next_in_switch", {6'd0, song_w[0]}, 8'd0);
        idle();
        check("extended_prst", {7'd0, prst_w[0]}, 8'd1);
        idle();
        check("extended_done", {6'd0, play_w[0], prst_w[0]}, 8'd2);

        // play toggle inside the window lands PAUSED
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check("toggle_in_switch", {6'd0, play_w[0], busy_w[0]}, 8'd0);

        // rewind/ff handling
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rew_wins", {6'd0, rew_w[0], ff_w[0]}, 8'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ff_alone", {6'd0, rew_w[0], ff_w[0]}, 8'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ff_cleared", {6'd0, rew_w[0], ff_w[0]}, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ff_paused", {7'd0, ff_w[0]}, 8'd0);

        // random phase
        rb_lvl = 1'b0;
        fb_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 10) rb_lvl = !rb_lvl;
            if ($urandom_range(0, 99) < 10) fb_lvl = !fb_lvl;
            step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 5, rb_lvl, fb_lvl,
                 $urandom_range(0, 99) < 8);
        end

        // asynchronous reset in the middle of a switch
        next_button = 1'b1;
        @(posedge clk);
        model_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("busy_before_reset", {6'd0, busy_w}, 8'd3);
        #1;
        next_button = 1'b0;
        play_button = 1'b0; prev_button = 1'b0; song_done = 1'b0;
        rewind_button = 1'b0; ff_button = 1'b0;
        reset = 1'b0;
        #1;
        check("async_reset_dut0", {1'b0, play_w[0], song_w[0], prst_w[0], rew_w[0], ff_w[0], busy_w[0]}, 8'h00);
        check("async_reset_dut1", {1'b0, play_w[1], song_w[1], prst_w[1], rew_w[1], ff_w[1], busy_w[1]}, 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (5) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/playback_ctrl.md
Name: playback_ctrl

Overview:
- Top-level sequencer for the song playback datapath.
- Turns debounced front-panel pulses (play/pause, next, prev) and rewind/ff levels into the play, song, rewind and ff controls of the song reader.
- Pulses a restart strobe so the reader's note counter and FSM re-initialise on every song change.
- Reacts to the reader's song_done by auto-advancing, looping or stopping.

Parameters:
- NUM_SONGS, 4: number of songs in ROM; song index wraps modulo NUM_SONGS.
- SONG_W, 2: width of the song select output; requires NUM_SONGS <= 2**SONG_W.
- SWITCH_CYCLES, 2: cycles player_reset is held during a song switch; legal range 1..15.
- LOOP, 1: 1 = after the last song, auto-advance wraps to song 0; 0 = stop.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_button  in  1  one-cycle pulse; toggle play/pause
- next_button  in  1  one-cycle pulse; select next song
- prev_button  in  1  one-cycle pulse; select previous song
- rewind_button  in  1  level; request rewind
- ff_button  in  1  level; request fast-forward
- song_done  in  1  one-cycle pulse from song reader at end of song
- play  out  1  run enable to song reader
- song  out  SONG_W  current song index
- player_reset  out  1  synchronous restart to song reader and note player
- rewind  out  1  rewind enable to song reader
- ff  out  1  fast-forward enable to song reader
- busy  out  1  high while a switch is in progress

Behaviour:
- States: PAUSED, PLAYING, SWITCH. Registers: state, song, resume flag, switch counter (4 bits), rewind, ff.
- Reset (reset=0, asynchronous):
  - state=PAUSED, song=0, resume=0, counter=0.
  - All outputs 0.
  - After release: first event is evaluated on the first rising edge.
- Outputs decoded from registered state:
  - play = (state==PLAYING)
  - player_reset = busy = (state==SWITCH)
- Event priority within one cycle: next_button > prev_button > song_done > play_button. Only the highest-priority event acts; the others are dropped.
- PAUSED:
  - play_button -> PLAYING.
  - next/prev -> SWITCH; song +/-1 mod NUM_SONGS; resume=0.
  - song_done ignored.
- PLAYING:
  - play_button -> PAUSED.
  - next/prev -> SWITCH; song +/-1 mod NUM_SONGS; resume=1.
  - song_done:
    - if song != NUM_SONGS-1 or LOOP=1 -> SWITCH, song +1 mod NUM_SONGS, resume=1;
    - else -> SWITCH, song unchanged, resume=0 (rewinds to start and stops).
- SWITCH:
  - counter loads SWITCH_CYCLES-1 on entry and decrements each cycle.
  - Exit when counter==0 and no event -> PLAYING if resume else PAUSED. player_reset is high for exactly SWITCH_CYCLES cycles.
  - next/prev during SWITCH: song +/-1 and counter reloads (restart window extends); resume kept.
  - play_button during SWITCH: toggles resume; counter not reloaded.
  - song_done ignored.
- Wrap-around: prev from song 0 -> NUM_SONGS-1; next from NUM_SONGS-1 -> 0.
- rewind/ff (registered, 1-cycle latency):
  - rewind <= rewind_button & (state==PLAYING)
  - ff <= ff_button & ~rewind_button & (state==PLAYING)
  - Both pressed -> rewind wins. Both cleared the cycle after leaving PLAYING.
- song changes on the same edge as entry to SWITCH and is stable throughout player_reset.
- song is never outside 0..NUM_SONGS-1.

Test Plan:
- Reset then idle 10 cycles -> play=0, song=0, player_reset=0, busy=0 throughout; assert reset mid-SWITCH -> all outputs 0 immediately (asynchronous).
- From PAUSED: pulse play_button -> play=1 next cycle; pulse again -> play=0; both pulses of next_button+play_button in same cycle -> SWITCH entered, song=1, play stays 0.
- PLAYING song=2: pulse next_button -> song=3, player_reset high exactly 2 cycles, then play=1; pulse next again after return -> song=0 (wrap); from song=0 pulse prev -> song=3.
- LOOP=1, PLAYING song=3: pulse song_done -> song=0, 2-cycle player_reset, play=1. LOOP=0, same stimulus -> song stays 3, player_reset 2 cycles, ends PAUSED (play=0).
- During SWITCH cycle 1: pulse next_button -> song advances again, player_reset total 3 cycles; pulse play_button in SWITCH from PLAYING -> ends PAUSED.
- PLAYING: hold rewind_button and ff_button -> rewind=1, ff=0 one cycle later; release rewind -> ff=1; pulse play_button -> rewind=ff=0 the cycle after play falls; ff_button while PAUSED -> ff stays 0.
